// File: rtl/spike_count_classifier.sv
// Counts spikes from three output neurons over a fixed window, then reports
// the winning neuron (argmax), tie and silence flags and the raw counts.
module spike_count_classifier #(
    parameter int WINDOW = 5,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         spike_in,
    input  logic               start,
    output logic               busy,
    output logic               result_valid,
    output logic [1:0]         result_class,
    output logic               result_tie,
    output logic               result_none,
    output logic [3*CNT_W-1:0] count_bus
);

    localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   cnt0;
    logic [CNT_W-1:0]   cnt1;
    logic [CNT_W-1:0]   cnt2;

    logic [1:0]         win_class;
    logic [CNT_W-1:0]   win_max;
    logic               win_tie;
    logic               win_none;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic hit);
        if (hit && (c != CNT_MAX)) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    // Strict greater-than keeps the lowest index on equal counts.
    function automatic logic [1:0] argmax(input logic [CNT_W-1:0] c0,
                                          input logic [CNT_W-1:0] c1,
                                          input logic [CNT_W-1:0] c2);
        logic [1:0]       idx;
        logic [CNT_W-1:0] best;
        idx  = 2'd0;
        best = c0;
        if (c1 > best) begin
            idx  = 2'd1;
            best = c1;
        end
        if (c2 > best) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] max3(input logic [CNT_W-1:0] c0,
                                              input logic [CNT_W-1:0] c1,
                                              input logic [CNT_W-1:0] c2);
        logic [CNT_W-1:0] m;
        m = c0;
        if (c1 > m) m = c1;
        if (c2 > m) m = c2;
        return m;
    endfunction

    function automatic logic multi_max(input logic [CNT_W-1:0] c0,
                                       input logic [CNT_W-1:0] c1,
                                       input logic [CNT_W-1:0] c2,
                                       input logic [CNT_W-1:0] m);
        logic e0, e1, e2;
        e0 = (c0 == m);
        e1 = (c1 == m);
        e2 = (c2 == m);
        return (e0 && e1) || (e0 && e2) || (e1 && e2);
    endfunction

    always_comb begin
        win_class = argmax(cnt0, cnt1, cnt2);
        win_max   = max3(cnt0, cnt1, cnt2);
        win_none  = (win_max == '0);
        win_tie   = !win_none && multi_max(cnt0, cnt1, cnt2, win_max);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            cnt0         <= '0;
            cnt1         <= '0;
            cnt2         <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_class <= 2'd0;
            result_tie   <= 1'b0;
            result_none  <= 1'b0;
            count_bus    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        timer <= '0;
                        cnt0  <= '0;
                        cnt1  <= '0;
                        cnt2  <= '0;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                // The last-timer edge still counts its spikes: WINDOW samples total.
                COUNT: begin
                    cnt0 <= sat_inc(cnt0, spike_in[0]);
                    cnt1 <= sat_inc(cnt1, spike_in[1]);
                    cnt2 <= sat_inc(cnt2, spike_in[2]);
                    if (timer == TMR_LAST) begin
                        state <= COMPARE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                COMPARE: begin
                    result_class <= win_class;
                    result_tie   <= win_tie;
                    result_none  <= win_none;
                    count_bus    <= {cnt2, cnt1, cnt0};
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench for spike_count_classifier: a wide-counter instance and a
// 2-bit saturating instance share the same stimulus and are checked together.
module tb_spike_count_classifier;

    localparam int WIN  = 5;
    localparam int CW_A = 8;
    localparam int CW_B = 2;

    logic                clk = 1'b0;
    logic                clk_en = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [2:0]          spike_in = 3'b000;

    logic                a_busy, a_valid, a_tie, a_none;
    logic [1:0]          a_class;
    logic [3*CW_A-1:0]   a_bus;
    logic                b_busy, b_valid, b_tie, b_none;
    logic [1:0]          b_class;
    logic [3*CW_B-1:0]   b_bus;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int c0;
        int c1;
        int c2;
        int cls;
        int tie;
        int none;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       last_a;
    logic [2:0] spk [WIN];

    spike_count_classifier #(.WINDOW(WIN), .CNT_W(CW_A)) dut_a (
        .clk(clk), .reset(reset), .spike_in(spike_in), .start(start),
        .busy(a_busy), .result_valid(a_valid), .result_class(a_class),
        .result_tie(a_tie), .result_none(a_none), .count_bus(a_bus)
    );

    spike_count_classifier #(.WINDOW(WIN), .CNT_W(CW_B)) dut_b (
        .clk(clk), .reset(reset), .spike_in(spike_in), .start(start),
        .busy(b_busy), .result_valid(b_valid), .result_class(b_class),
        .result_tie(b_tie), .result_none(b_none), .count_bus(b_bus)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int vcyc, input int sat);
        exp_t e;
        int   c[3];
        int   m, num;
        c = '{0, 0, 0};
        for (int k = 0; k < WIN; k++)
            for (int i = 0; i < 3; i++)
                if (spk[k][i] && c[i] < sat) c[i]++;
        m = c[0];
        for (int i = 1; i < 3; i++) if (c[i] > m) m = c[i];
        e.cls = -1;
        num = 0;
        for (int i = 0; i < 3; i++) begin
            if (c[i] == m) begin
                num++;
                if (e.cls < 0) e.cls = i;
            end
        end
        e.cyc  = vcyc;
        e.c0   = c[0];
        e.c1   = c[1];
        e.c2   = c[2];
        e.none = (m == 0) ? 1 : 0;
        e.tie  = (num >= 2 && m > 0) ? 1 : 0;
        return e;
    endfunction

    task automatic cmp(input string who, input exp_t e, input logic [1:0] cls,
                       input logic tie, input logic none, input int c0,
                       input int c1, input int c2);
        chk({who, "_latency"}, cyc, e.cyc);
        chk({who, "_class"}, cls, e.cls);
        chk({who, "_tie"}, tie, e.tie);
        chk({who, "_none"}, none, e.none);
        chk({who, "_count0"}, c0, e.c0);
        chk({who, "_count1"}, c1, e.c1);
        chk({who, "_count2"}, c2, e.c2);
    endtask

    always @(negedge clk) begin
        if (a_valid) begin
            if (qa.size() == 0) chk("a_unexpected_valid", a_valid, 0);
            else cmp("a", qa.pop_front(), a_class, a_tie, a_none,
                     int'(a_bus[0 +: CW_A]), int'(a_bus[CW_A +: CW_A]),
                     int'(a_bus[2*CW_A +: CW_A]));
        end
        if (b_valid) begin
            if (qb.size() == 0) chk("b_unexpected_valid", b_valid, 0);
            else cmp("b", qb.pop_front(), b_class, b_tie, b_none,
                     int'(b_bus[0 +: CW_B]), int'(b_bus[CW_B +: CW_B]),
                     int'(b_bus[2*CW_B +: CW_B]));
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_a_busy"}, a_busy, 0);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_a_class"}, a_class, 0);
        chk({tag, "_a_tie"}, a_tie, 0);
        chk({tag, "_a_none"}, a_none, 0);
        chk({tag, "_a_bus"}, a_bus, 0);
        chk({tag, "_b_busy"}, b_busy, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_b_bus"}, b_bus, 0);
        last_a = '{default: 0};
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_window(input bit extra_start);
        exp_t hold;
        exp_t e;
        hold     = last_a;
        start    = 1'b1;
        spike_in = 3'b000;
        e = model(cyc + 1 + WIN + 1, (1 << CW_A) - 1);
        qa.push_back(e);
        last_a = e;
        qb.push_back(model(cyc + 1 + WIN + 1, (1 << CW_B) - 1));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", a_busy, 1);
        for (int k = 0; k < WIN; k++) begin
            spike_in = spk[k];
            start    = (extra_start && k == 1);
            @(negedge clk);
            chk("busy_counting", a_busy, 1);
            chk("hold_class", a_class, hold.cls);
            chk("hold_count1", a_bus[CW_A +: CW_A], hold.c1);
        end
        start    = 1'b0;
        spike_in = 3'b111;
        @(negedge clk);
        chk("busy_compare_done", b_busy, 1);
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        chk("a_busy_back_idle", a_busy, 0);
        chk("b_busy_back_idle", b_busy, 0);
        spike_in = 3'b000;
    endtask

    initial begin
        last_a = '{default: 0};
        #2 reset = 1'b1;
        #1 check_zero("por_stopped_clk");
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("busy_after_release", a_busy, 0);

        spk = '{3'b010, 3'b110, 3'b010, 3'b000, 3'b100};
        run_window(1'b0);
        spk = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
        run_window(1'b0);
        spk = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        run_window(1'b0);
        spk = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        run_window(1'b0);
        spk = '{3'b110, 3'b011, 3'b010, 3'b100, 3'b001};
        run_window(1'b1);
        for (int w = 0; w < 6; w++) begin
            foreach (spk[k]) spk[k] = 3'($urandom_range(0, 7));
            run_window(w[0]);
        end
        spk = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b011};
        run_window(1'b0);

        // Reset with the clock parked low must clear held results at once.
        clk_en = 1'b0;
        #20 reset = 1'b1;
        #1 check_zero("stopped_clk_reset");
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Abort a window in its third cycle after an ignored second start.
        start    = 1'b1;
        spike_in = 3'b000;
        @(negedge clk);
        start    = 1'b0;
        spike_in = 3'b111;
        chk("abort_busy_started", a_busy, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero("abort_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (WIN + 4) begin
            @(negedge clk);
            chk("abort_stays_idle", a_busy, 0);
        end
        spike_in = 3'b000;

        spk = '{3'b010, 3'b011, 3'b111, 3'b010, 3'b001};
        run_window(1'b0);
        repeat (3) @(negedge clk);

        chk("a_results_pending", qa.size(), 0);
        chk("b_results_pending", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_count_classifier.md
SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 Parameter WINDOW, default 5: number of clock cycles in one counting window; SHALL be >= 1.
REQ-002 Parameter CNT_W, default 8: width of each per-neuron spike counter; SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 spike_in  input  3  output spikes of the 2-layer IF network; bit i is neuron i, one spike per cycle max.
REQ-006 start  input  1  single-cycle request to begin one counting window.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 result_valid  output  1  one-cycle pulse; result outputs are updated in the same cycle.
REQ-009 result_class  output  2  index (0..2) of the neuron with the highest count.
REQ-010 result_tie  output  1  high when two or more neurons share the maximum count and that count is nonzero.
REQ-011 result_none  output  1  high when all three counts are zero.
REQ-012 count_bus  output  3*CNT_W  final counts; neuron i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-013 The FSM SHALL have four states: IDLE, COUNT, COMPARE, DONE.
REQ-014 IDLE: if start=1 at an edge, clear all counters and the window timer, then go to COUNT; otherwise hold.
REQ-015 start SHALL be sampled only in IDLE; start in COUNT, COMPARE or DONE SHALL be ignored, with no queueing.
REQ-016 COUNT: on each edge, counter i SHALL increment by 1 when spike_in[i]=1, and the window timer SHALL increment.
REQ-017 The COUNT edge at which the timer equals WINDOW-1 SHALL count its spikes and move to COMPARE; spike_in SHALL therefore be sampled on exactly WINDOW edges.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 The window timer SHALL be wide enough for WINDOW-1 (clog2, minimum 1 bit).
REQ-020 COMPARE: at the next edge, register result_class, result_tie, result_none and count_bus, assert result_valid, and go to DONE.
REQ-021 Argmax SHALL use unsigned compare; on a tie, the lowest index SHALL win.
REQ-022 When all counts are zero: result_class=0, result_none=1, result_tie=0.
REQ-023 DONE: at the next edge, deassert result_valid and go to IDLE.
REQ-024 Latency: start sampled at edge E0 gives result_valid=1 for exactly one cycle, from edge E(WINDOW+1) to edge E(WINDOW+2).
REQ-025 result_class, result_tie, result_none and count_bus SHALL hold their last values until the next result_valid or reset.
REQ-026 spike_in SHALL be ignored in IDLE, COMPARE and DONE.
REQ-027 A window SHALL take WINDOW+3 cycles, start edge included; the earliest back-to-back start is the edge after DONE.

Reset
REQ-028 While reset=1: the FSM SHALL be in IDLE, and counters, timer, busy, result_valid, result_class, result_tie, result_none and count_bus SHALL all be 0, taking effect immediately without waiting for a clock edge.
REQ-029 Reset asserted mid-window SHALL abort the window; no result_valid SHALL be produced for it.
REQ-030 The first start accepted after reset deasserts SHALL be at the first rising edge where reset=0 and start=1.

Verification
REQ-031 Reset: assert reset with clk stopped -> all outputs 0 immediately; busy=0 after release.
REQ-032 Distinct winner: start; spike_in = 010, 110, 010, 000, 100 over 5 cycles -> count_bus {2,3,0}, result_class=1, tie=0, none=0, result_valid exactly 6 cycles after start edge.
REQ-033 Tie: start; spike_in=101 for 5 cycles -> counts {5,0,5}, result_class=0, result_tie=1.
REQ-034 Silence: start; spike_in=000 for 5 cycles -> result_none=1, result_class=0, result_tie=0, counts all 0.
REQ-035 Saturation (CNT_W=2, WINDOW=5): spike_in=001 for all cycles -> count0=3, result_class=0.
REQ-036 Abort/ignore: start; pulse start again in cycle 2 -> ignored. Assert reset in cycle 3 -> busy=0 at once, no result_valid; a new start after release gives a clean full window.
